// File: rtl/cache_mem_arbiter.sv
// Shares one SRAM-like memory port between the I-cache and D-cache paths.
// One outstanding transaction; the owner is locked from grant until its data_ok.
module cache_mem_arbiter #(
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;
  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  // Handshake: a requester holds req (and its fields) until its addr_ok;
  // addr_ok means the bridge took the address this cycle, data_ok ends the
  // transaction. Both ok strobes only ever go to the current grantee.
  state_t     state;
  logic       owner;
  logic       last;
  logic [3:0] starve_cnt;

  logic any_req;
  logic sel;
  logic grantee;
  logic addr_acc;
  logic data_acc;

  always_comb begin
    any_req = i_req | d_req;
    sel     = d_req ? SRC_D : SRC_I;
    if (i_req && d_req) begin
      if (RR_MODE != 0) sel = ~last;
      else              sel = (starve_cnt >= MAX_WAIT_L) ? SRC_I : SRC_D;
    end
    // In IDLE the grant is zero-latency; afterwards it is locked to owner.
    grantee = (state == IDLE) ? sel : owner;

    mem_req   = !rst && (((state == IDLE) && any_req) || (state == ADDR));
    mem_wr    = (grantee == SRC_D) ? d_wr    : i_wr;
    mem_size  = (grantee == SRC_D) ? d_size  : i_size;
    mem_addr  = (grantee == SRC_D) ? d_addr  : i_addr;
    mem_wdata = (grantee == SRC_D) ? d_wdata : i_wdata;

    addr_acc = mem_req && mem_addr_ok;
    // A stray data_ok with no accepted address is dropped here.
    data_acc = !rst && mem_data_ok && ((state == DATA) || addr_acc);

    i_addr_ok = addr_acc && (grantee == SRC_I);
    d_addr_ok = addr_acc && (grantee == SRC_D);
    i_data_ok = data_acc && (grantee == SRC_I);
    d_data_ok = data_acc && (grantee == SRC_D);

    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= SRC_I;
      last       <= SRC_I;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (!mem_addr_ok) begin
              owner <= sel;
              state <= ADDR;
            end else if (!mem_data_ok) begin
              owner <= sel;
              state <= DATA;
            end
          end
        end
        ADDR: begin
          if (mem_addr_ok) state <= mem_data_ok ? IDLE : DATA;
        end
        DATA: begin
          if (mem_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Starvation counts D grants taken while I was left waiting.
      if (addr_acc) begin
        last <= grantee;
        if ((grantee == SRC_I) || !i_req) starve_cnt <= 4'd0;
        else if (starve_cnt != 4'hf)      starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule
